// File: rtl/lhn_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lhn_cache_ctrl_if
//  Brief    : CPU-side and memory-side bus bundle for lhn_cache_ctrl.
//             The slave modport is the cache controller's view; the master
//             modport is the requester / memory model view.
//  Revision : 1.0 - initial release
// ============================================================================
interface lhn_cache_ctrl_if #(
    parameter int DW = 9
);
    logic          cpu_req;
    logic [13:0]   cpu_addr;
    logic          cpu_ack;
    logic          cpu_hit;
    logic [DW-1:0] cpu_dout;
    logic          mem_req;
    logic [10:0]   mem_addr;
    logic          mem_valid;
    logic [DW-1:0] mem_data;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_addr, mem_valid, mem_data,
        output cpu_ack, cpu_hit, cpu_dout, mem_req, mem_addr, busy
    );

    modport master (
        output cpu_req, cpu_addr, mem_valid, mem_data,
        input  cpu_ack, cpu_hit, cpu_dout, mem_req, mem_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/lhn_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lhn_cache_ctrl
//  Brief    : Read-only 2-way set-associative cache controller, 8 sets,
//             8-word lines, block fill from memory in word order 0..7.
//             Optional macro LHN_LRU_EN selects LRU replacement; when it is
//             not defined the per-set bit is a FIFO victim pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module lhn_cache_ctrl #(
    parameter int DW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    lhn_cache_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          state_q;
    logic [13:0]     addr_q;
    logic [7:0][1:0] valid_q;
    logic [7:0]      repl_q;
    logic [2:0]      beat_q;
    logic            victim_q;
    logic            ack_q;
    logic            hit_q;
    logic [DW-1:0]   dout_q;
    logic            mem_req_q;
    logic [10:0]     mem_addr_q;

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    logic [7:0]      tag_q  [8][2];
    logic [DW-1:0]   data_q [8][2][8];

    logic [7:0]      w_tag;
    logic [2:0]      w_set;
    logic [2:0]      w_word;
    logic            w_hit0;
    logic            w_hit1;
    logic            w_victim;
    logic            w_fill_we;
    logic            w_last;
    logic [DW-1:0]   w_fill_word;

    assign w_tag  = addr_q[13:6];
    assign w_set  = addr_q[5:3];
    assign w_word = addr_q[2:0];

    assign w_hit0 = valid_q[w_set][0] && (tag_q[w_set][0] == w_tag);
    assign w_hit1 = valid_q[w_set][1] && (tag_q[w_set][1] == w_tag);

    // Lowest invalid way first, otherwise the replacement bit decides.
    assign w_victim = !valid_q[w_set][0] ? 1'b0 :
                      !valid_q[w_set][1] ? 1'b1 : repl_q[w_set];

    assign w_fill_we = (state_q == S_FILL) && bus.mem_valid;
    assign w_last    = w_fill_we && (beat_q == 3'd7);

    // Word 7 is being written this very cycle, so take it from the bus.
    assign w_fill_word = (w_word == 3'd7) ? bus.mem_data
                                          : data_q[w_set][victim_q][w_word];

    assign bus.cpu_ack  = ack_q;
    assign bus.cpu_hit  = hit_q;
    assign bus.cpu_dout = dout_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.busy     = (state_q != S_IDLE);

    // Control FSM with registered responses, valid and replacement state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            repl_q     <= '0;
            beat_q     <= '0;
            victim_q   <= 1'b0;
            ack_q      <= 1'b0;
            hit_q      <= 1'b0;
            dout_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        addr_q  <= bus.cpu_addr;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit0 || w_hit1) begin
                        hit_q   <= 1'b1;
                        dout_q  <= data_q[w_set][w_hit1][w_word];
                        ack_q   <= 1'b1;
                        state_q <= S_RESP;
`ifdef LHN_LRU_EN
                        repl_q[w_set] <= ~w_hit1;
`endif
                    end else begin
                        victim_q   <= w_victim;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {w_tag, w_set};
                        beat_q     <= 3'd0;
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_valid) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            valid_q[w_set][victim_q] <= 1'b1;
                            mem_req_q <= 1'b0;
                            hit_q     <= 1'b0;
                            dout_q    <= w_fill_word;
                            ack_q     <= 1'b1;
                            state_q   <= S_RESP;
`ifdef LHN_LRU_EN
                            repl_q[w_set] <= ~victim_q;
`else
                            repl_q[w_set] <= ~repl_q[w_set];
`endif
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line fill writes: one data word per beat, tag on the final beat.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            data_q[w_set][victim_q][beat_q] <= bus.mem_data;
        end
        if (w_last) begin
            tag_q[w_set][victim_q] <= w_tag;
        end
    end

endmodule
`default_nettype wire
